// File: rtl/fpu_wb_queue.sv
// FPU writeback queue: buffers non-stallable FPU results in a circular FIFO and
// drains them over a valid/ready port, with a credit counter gating new issues.
module fpu_wb_queue #(
    parameter int LG_PRF_WIDTH = 4,
    parameter int LG_ROB_WIDTH = 4,
    parameter int LG_FCR_WIDTH = 4,
    parameter int LG_Q_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fpu_start,
    input  logic                    fpu_val,
    input  logic                    fpu_cmp_val,
    input  logic [63:0]             fpu_y,
    input  logic [LG_ROB_WIDTH-1:0] fpu_rob_ptr,
    input  logic [LG_PRF_WIDTH-1:0] fpu_dst_ptr,
    input  logic [LG_FCR_WIDTH-1:0] fpu_fcr_ptr,
    output logic                    issue_ok,
    output logic                    wb_val,
    input  logic                    wb_ready,
    output logic                    wb_is_fcr,
    output logic [63:0]             wb_data,
    output logic [LG_ROB_WIDTH-1:0] wb_rob_ptr,
    output logic [LG_PRF_WIDTH-1:0] wb_dst_ptr,
    output logic [LG_FCR_WIDTH-1:0] wb_fcr_ptr,
    output logic                    err
);

    localparam int DEPTH = 1 << LG_Q_DEPTH;
    localparam logic [LG_Q_DEPTH:0]   CNT_FULL = (LG_Q_DEPTH+1)'(DEPTH);
    localparam logic [LG_Q_DEPTH:0]   CNT_ONE  = (LG_Q_DEPTH+1)'(1);
    localparam logic [LG_Q_DEPTH-1:0] PTR_ONE  = LG_Q_DEPTH'(1);

    typedef struct packed {
        logic                    is_fcr;
        logic [63:0]             data;
        logic [LG_ROB_WIDTH-1:0] rob;
        logic [LG_PRF_WIDTH-1:0] dst;
        logic [LG_FCR_WIDTH-1:0] fcr;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [LG_Q_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LG_Q_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LG_Q_DEPTH:0]   occ_q, occ_d;
    logic [LG_Q_DEPTH:0]   r_resv_q, r_resv_d;
    logic                  err_q, err_d;

    logic   enq, enq_ok, deq, full, start_ok, underflow;
    entry_t wr_entry, head;

    always_comb begin
        enq      = fpu_val | fpu_cmp_val;
        full     = (occ_q == CNT_FULL);
        enq_ok   = enq & ~full;
        wb_val   = (occ_q != '0);
        deq      = wb_val & wb_ready;
        issue_ok = (r_resv_q < CNT_FULL);
        start_ok = fpu_start & issue_ok;
        // A drain with no outstanding credit means a result arrived unissued.
        underflow = deq & ~start_ok & (r_resv_q == '0);

        wr_entry.is_fcr = fpu_cmp_val;
        wr_entry.data   = fpu_y;
        wr_entry.rob    = fpu_rob_ptr;
        wr_entry.dst    = fpu_dst_ptr;
        wr_entry.fcr    = fpu_fcr_ptr;

        wr_ptr_d = enq_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = deq    ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        occ_d = occ_q;
        case ({enq_ok, deq})
            2'b10:   occ_d = occ_q + CNT_ONE;
            2'b01:   occ_d = occ_q - CNT_ONE;
            default: occ_d = occ_q;
        endcase

        r_resv_d = r_resv_q;
        case ({start_ok, deq})
            2'b10:   r_resv_d = r_resv_q + CNT_ONE;
            2'b01:   r_resv_d = underflow ? r_resv_q : r_resv_q - CNT_ONE;
            default: r_resv_d = r_resv_q;
        endcase

        err_d = err_q
              | (fpu_val & fpu_cmp_val)
              | (enq & full)
              | underflow
              | (fpu_start & ~issue_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            r_resv_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            r_resv_q <= r_resv_d;
            err_q    <= err_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        err        = err_q;
        wb_is_fcr  = wb_val ? head.is_fcr : 1'b0;
        wb_data    = wb_val ? head.data   : '0;
        wb_rob_ptr = wb_val ? head.rob    : '0;
        wb_dst_ptr = wb_val ? head.dst    : '0;
        wb_fcr_ptr = wb_val ? head.fcr    : '0;
    end

endmodule

// File: tb/tb_fpu_wb_queue.sv
// Directed self-checking bench for fpu_wb_queue (default params, DEPTH=4).
module tb_fpu_wb_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        fpu_start, fpu_val, fpu_cmp_val;
    logic [63:0] fpu_y;
    logic [3:0]  fpu_rob_ptr, fpu_dst_ptr, fpu_fcr_ptr;
    logic        issue_ok, wb_val, wb_ready, wb_is_fcr, err;
    logic [63:0] wb_data;
    logic [3:0]  wb_rob_ptr, wb_dst_ptr, wb_fcr_ptr;

    int n_chk = 0;
    int n_err = 0;

    fpu_wb_queue dut (
        .clk(clk), .reset(reset),
        .fpu_start(fpu_start), .fpu_val(fpu_val), .fpu_cmp_val(fpu_cmp_val),
        .fpu_y(fpu_y), .fpu_rob_ptr(fpu_rob_ptr), .fpu_dst_ptr(fpu_dst_ptr),
        .fpu_fcr_ptr(fpu_fcr_ptr), .issue_ok(issue_ok), .wb_val(wb_val),
        .wb_ready(wb_ready), .wb_is_fcr(wb_is_fcr), .wb_data(wb_data),
        .wb_rob_ptr(wb_rob_ptr), .wb_dst_ptr(wb_dst_ptr), .wb_fcr_ptr(wb_fcr_ptr),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        fpu_start   = 1'b0;
        fpu_val     = 1'b0;
        fpu_cmp_val = 1'b0;
        fpu_y       = '0;
        fpu_rob_ptr = '0;
        fpu_dst_ptr = '0;
        fpu_fcr_ptr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int got_n, starts, res_idx;
        logic pend, pend_nx;

        reset = 1'b0; clr(); wb_ready = 1'b0;
        step(); step();
        chk("rst_wb_val",   64'(wb_val),   64'd0);
        chk("rst_issue_ok", 64'(issue_ok), 64'd1);
        chk("rst_err",      64'(err),      64'd0);
        chk("rst_wb_data",  wb_data,       64'd0);
        reset = 1'b1;

        // single op: start @t0, result @t2, visible @t3, gone @t4
        fpu_start = 1'b1; step(); fpu_start = 1'b0;
        chk("single_resv1", 64'(dut.r_resv_q), 64'd1);
        step();
        fpu_val = 1'b1; fpu_y = 64'h3FF0000000000000; fpu_dst_ptr = 4'd5; fpu_rob_ptr = 4'd3;
        wb_ready = 1'b1;
        chk("single_no_early", 64'(wb_val), 64'd0);
        step(); clr();
        chk("single_val",  64'(wb_val),     64'd1);
        chk("single_data", wb_data,         64'h3FF0000000000000);
        chk("single_dst",  64'(wb_dst_ptr), 64'd5);
        chk("single_rob",  64'(wb_rob_ptr), 64'd3);
        chk("single_fcr",  64'(wb_is_fcr),  64'd0);
        step();
        chk("single_gone", 64'(wb_val),     64'd0);
        chk("single_resv0", 64'(dut.r_resv_q), 64'd0);
        chk("single_err",  64'(err),        64'd0);

        // back-pressure: 4 credits, 5th start errors, drain in order
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fpu_start = 1'b1; step();
            chk("bp_issue_ok", 64'(issue_ok), (i < 3) ? 64'd1 : 64'd0);
        end
        step(); fpu_start = 1'b0;
        chk("bp_err5",  64'(err),          64'd1);
        chk("bp_resv4", 64'(dut.r_resv_q), 64'd4);
        for (int i = 0; i < 4; i++) begin
            fpu_val = 1'b1; fpu_y = 64'(256 + i); fpu_rob_ptr = 4'(i);
            step();
        end
        clr();
        chk("bp_occ4", 64'(dut.occ_q), 64'd4);
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_head_data", wb_data,         64'(256 + i));
            chk("bp_head_rob",  64'(wb_rob_ptr), 64'(i));
            step();
            chk("bp_issue_after", 64'(issue_ok), 64'd1);
        end
        chk("bp_empty", 64'(wb_val), 64'd0);
        wb_ready = 1'b0;
        #3 reset = 1'b0;
        #1 chk("bp_err_cleared", 64'(err), 64'd0);
        reset = 1'b1;
        step();

        // compare result
        fpu_start = 1'b1; step(); fpu_start = 1'b0;
        fpu_cmp_val = 1'b1; fpu_y = 64'h4; fpu_fcr_ptr = 4'd2;
        step(); clr();
        chk("cmp_val",  64'(wb_val),     64'd1);
        chk("cmp_fcr",  64'(wb_is_fcr),  64'd1);
        chk("cmp_data", wb_data,         64'd4);
        chk("cmp_ptr",  64'(wb_fcr_ptr), 64'd2);
        wb_ready = 1'b1; step(); wb_ready = 1'b0;
        chk("cmp_gone", 64'(wb_val), 64'd0);
        chk("cmp_err",  64'(err),    64'd0);

        // occupancy 1: dequeue A while enqueuing B
        fpu_start = 1'b1; step(); step(); fpu_start = 1'b0;
        fpu_val = 1'b1; fpu_y = 64'hAAAA; step();
        fpu_y = 64'hBBBB; wb_ready = 1'b1;
        chk("occ1_head_a", wb_data, 64'hAAAA);
        step(); clr();
        chk("occ1_head_b", wb_data,        64'hBBBB);
        chk("occ1_occ",    64'(dut.occ_q), 64'd1);
        step();
        chk("occ1_empty", 64'(wb_val), 64'd0);
        wb_ready = 1'b0;
        chk("occ1_err",  64'(err),          64'd0);
        chk("occ1_resv", 64'(dut.r_resv_q), 64'd0);

        // wrap-around stream of 10 results, FPU latency 1, toggling ready
        got_n = 0; starts = 0; res_idx = 0; pend = 1'b0;
        for (int cyc = 0; cyc < 200 && got_n < 10; cyc++) begin
            fpu_val     = pend;
            fpu_y       = 64'(40960 + res_idx);
            fpu_rob_ptr = 4'(res_idx);
            pend_nx     = (starts < 10) && issue_ok;
            fpu_start   = pend_nx;
            wb_ready    = (cyc % 2) == 1;
            if (wb_val && wb_ready) begin
                chk("wrap_data", wb_data, 64'(40960 + got_n));
                got_n++;
            end
            step();
            if (pend) res_idx++;
            pend = pend_nx;
            if (pend_nx) starts++;
        end
        clr(); wb_ready = 1'b0;
        chk("wrap_count", 64'(got_n), 64'd10);
        chk("wrap_err",   64'(err),   64'd0);
        chk("wrap_empty", 64'(wb_val), 64'd0);

        // async reset mid-cycle with occupancy 3 and err set
        fpu_start = 1'b1; step(); step(); step(); fpu_start = 1'b0;
        fpu_val = 1'b1; fpu_y = 64'h11; step();
        fpu_y = 64'h22; step();
        fpu_cmp_val = 1'b1; fpu_y = 64'h33; step();
        clr();
        chk("ar_occ3", 64'(dut.occ_q), 64'd3);
        chk("ar_err1", 64'(err),       64'd1);
        #3 reset = 1'b0;
        #1;
        chk("ar_wb_val",   64'(wb_val),   64'd0);
        chk("ar_issue_ok", 64'(issue_ok), 64'd1);
        chk("ar_err",      64'(err),      64'd0);
        chk("ar_wb_data",  wb_data,       64'd0);
        #2 reset = 1'b1;
        fpu_start = 1'b1; fpu_val = 1'b1; fpu_y = 64'hC0DE; fpu_dst_ptr = 4'd9;
        step(); clr();
        chk("ar_new_val",  64'(wb_val),     64'd1);
        chk("ar_new_data", wb_data,         64'hC0DE);
        chk("ar_new_dst",  64'(wb_dst_ptr), 64'd9);
        wb_ready = 1'b1; step(); wb_ready = 1'b0;
        chk("ar_drained",  64'(wb_val),          64'd0);
        chk("ar_end_err",  64'(err),             64'd0);
        chk("ar_end_resv", 64'(dut.r_resv_q),    64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_wb_queue.md
FPU_WB_QUEUE -- requirements
Module: fpu_wb_queue

Interface
- REQ-001: Parameters, one per line (name, default, meaning):
  - LG_PRF_WIDTH, 4, physical register pointer width.
  - LG_ROB_WIDTH, 4, ROB pointer width.
  - LG_FCR_WIDTH, 4, FCR rename pointer width.
  - LG_Q_DEPTH, 2, log2 of queue depth (DEPTH = 2**LG_Q_DEPTH).
- REQ-002: Ports, one per line (name, direction, width, meaning):
  - clk, in, 1, the single clock.
  - reset, in, 1, asynchronous, active-low reset.
  - fpu_start, in, 1, FPU op issued this cycle.
  - fpu_val, in, 1, FPU data result valid.
  - fpu_cmp_val, in, 1, FPU compare/FCR result valid.
  - fpu_y, in, 64, FPU result.
  - fpu_rob_ptr, in, LG_ROB_WIDTH, ROB tag of the result.
  - fpu_dst_ptr, in, LG_PRF_WIDTH, destination PRF pointer.
  - fpu_fcr_ptr, in, LG_FCR_WIDTH, destination FCR pointer.
  - issue_ok, out, 1, FPU may accept fpu_start this cycle.
  - wb_val, out, 1, head entry valid.
  - wb_ready, in, 1, writeback port accepts the head.
  - wb_is_fcr, out, 1, head is an FCR (compare) write.
  - wb_data, out, 64, head result.
  - wb_rob_ptr, out, LG_ROB_WIDTH, head ROB tag.
  - wb_dst_ptr, out, LG_PRF_WIDTH, head PRF pointer.
  - wb_fcr_ptr, out, LG_FCR_WIDTH, head FCR pointer.
  - err, out, 1, sticky protocol-error flag.
- REQ-003: Clock and reset are as decided: one clock; reset is asynchronous and active-low.

Function
- REQ-004: The block SHALL buffer FPU results, which cannot stall, in a DEPTH-entry circular FIFO and drain them over a valid/ready writeback port.
- REQ-005: An enqueue SHALL occur in any cycle where fpu_val or fpu_cmp_val is 1.
  - Entry fields: data=fpu_y, is_fcr=fpu_cmp_val, and all three pointers.
- REQ-006: An enqueued entry SHALL be visible at the head no earlier than the following cycle (one-cycle registered latency, no combinational bypass).
- REQ-007: A dequeue SHALL occur when wb_val and wb_ready are both 1.
- REQ-008: wb_val SHALL equal (occupancy != 0).
- REQ-009: wb_* fields SHALL present the head entry when wb_val=1 and all-zero when wb_val=0.
- REQ-010: Read and write pointers SHALL wrap modulo DEPTH.
  - Occupancy SHALL be tracked in LG_Q_DEPTH+1 bits, so full (DEPTH) and empty (0) are distinguishable.
- REQ-011: On simultaneous enqueue and dequeue, occupancy SHALL be unchanged, pointers SHALL each advance, and order SHALL be preserved.
  - This holds when occupancy is 1: the old head leaves and the new entry becomes head next cycle.
- REQ-012: Credit counter r_resv (LG_Q_DEPTH+1 bits) SHALL update each cycle as follows:
  - +1 on fpu_start with issue_ok=1.
  - −1 on dequeue.
  - Unchanged when both occur.
- REQ-013: issue_ok SHALL be 1 iff r_resv < DEPTH, guaranteeing that every in-flight result finds a free slot regardless of FPU latency.
- REQ-014: fpu_start while issue_ok=0 SHALL NOT change r_resv and SHALL set err.
- REQ-015: err SHALL set on any of the following; once set, it holds until reset:
  - fpu_val and fpu_cmp_val both 1.
  - Enqueue while occupancy=DEPTH.
  - Dequeue-side underflow of r_resv.
- REQ-016: An enqueue while full SHALL be dropped, with pointers and occupancy unchanged.
- REQ-017: wb_ready while wb_val=0 SHALL have no effect.

Reset
- REQ-018: While reset=0, the following SHALL be forced to 0 asynchronously:
  - Read pointer, write pointer, occupancy, r_resv and err.
  - Therefore wb_val=0, issue_ok=1 and all wb_* fields=0.
- REQ-019: FIFO data storage SHALL NOT require reset.
- REQ-020: Results arriving in the first cycle after reset deassertion SHALL be enqueued normally.
- REQ-021: Results of operations in flight when reset asserts SHALL be discarded, since the FPU itself is reset.

Verification
- REQ-022: Single op: fpu_start @t0, fpu_val @t2 with fpu_y=64'h3FF0000000000000, dst=5, rob=3, wb_ready=1.
  - wb_val=1 @t3 with data=64'h3FF0000000000000, dst=5, rob=3, is_fcr=0.
  - wb_val=0 @t4; r_resv returns 0.
- REQ-023: Back-pressure, DEPTH=4, wb_ready=0: issue 4 starts.
  - issue_ok=0 after the 4th start.
  - 5th start sets err=1.
  - Raising wb_ready drains 4 entries in issue order, 1 per cycle; issue_ok=1 after the first drain.
- REQ-024: Compare result: fpu_cmp_val=1 with fpu_y=64'h0000000000000004, fcr=2.
  - Next cycle: wb_is_fcr=1, wb_data=4, wb_fcr_ptr=2.
- REQ-025: Occupancy 1 with head A, wb_ready=1, and new result B in the same cycle.
  - Next cycle: head=B, occupancy=1.
  - Following cycle: wb_val=0.
- REQ-026: Wrap-around: stream 10 results with wb_ready toggling every cycle.
  - All 10 drain in order with no loss, and err stays 0.
- REQ-027: Assert reset=0 mid-cycle with occupancy 3.
  - wb_val=0, issue_ok=1 and err=0 immediately, without waiting for a clock edge.
  - After release, a new result drains correctly.
